// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator / differentiator pair.
package acc_pkg;

  localparam int unsigned ACC_WIDTH = 8;
  localparam int unsigned ACC_INIT  = 0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } diff_state_t;

endpackage

// File: rtl/acc_differentiator_if.sv
// Sample/result stream between the accumulator, the differentiator and its consumer.
interface acc_differentiator_if
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH     = ACC_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     in;
  logic                 ceDiff;
  logic                 inReady;
  logic                 restart;
  logic [WIDTH-1:0]     out;
  logic                 outValid;
  logic                 outReady;
  logic [CNT_WIDTH-1:0] count;

  modport master (
    output in, ceDiff, restart, outReady,
    input  inReady, out, outValid, count
  );

  modport slave (
    input  in, ceDiff, restart, outReady,
    output inReady, out, outValid, count
  );
endinterface

// File: rtl/acc_out_stage.sv
// One-entry valid/ready output register; produces the accept and consume strobes.
module acc_out_stage
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             in_ready,
  output logic             accept,
  output logic             consume,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  diff_state_t      state_q;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    dout_valid = (state_q == FULL);
    dout       = data_q;
    in_ready   = !dout_valid || dout_ready;
    accept     = load && in_ready && !flush;
    consume    = dout_valid && dout_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else if (flush) begin
      // Pending result is dropped; data is left as-is.
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
            data_q  <= din;
          end
        end
        FULL: begin
          if (accept) begin
            data_q <= din;
          end else if (dout_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/acc_differentiator.sv
// Recovers increments from a running-sum stream: out = in - previous in (mod 2^WIDTH).
module acc_differentiator
  import acc_pkg::*;
#(
  parameter int unsigned      WIDTH     = ACC_WIDTH,
  parameter logic [WIDTH-1:0] INIT      = WIDTH'(ACC_INIT),
  parameter int unsigned      CNT_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  acc_differentiator_if.slave bus
);

  logic [WIDTH-1:0]     prev_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [WIDTH-1:0]     diff;
  logic                 accept;
  logic                 consume;

  assign diff = bus.in - prev_q;

  acc_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.restart),
    .load       (bus.ceDiff),
    .din        (diff),
    .in_ready   (bus.inReady),
    .accept     (accept),
    .consume    (consume),
    .dout       (bus.out),
    .dout_valid (bus.outValid),
    .dout_ready (bus.outReady)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.restart) begin
      prev_q <= INIT;
    end else if (accept) begin
      prev_q <= bus.in;
    end
  end

  // A result discarded by restart is not counted as consumed.
  always_ff @(posedge clk) begin
    if (rst || bus.restart) begin
      count_q <= '0;
    end else if (consume) begin
      count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.count = count_q;

endmodule

// File: tb/tb_acc_differentiator.sv
// Self-checking bench for acc_differentiator: directed tables plus a scoreboarded model.
module tb_acc_differentiator;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_differentiator_if #(.WIDTH(8), .CNT_WIDTH(16)) bus ();

  acc_differentiator #(.WIDTH(8), .INIT(8'd0), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] in;
    logic [7:0] exp;
  } vec_t;

  logic [7:0] sb[$];
  bit         loop_mode = 1'b0;
  logic [7:0] m_prev;
  bit         m_valid;
  int         m_count;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle on the current inputs.
  always @(negedge clk) begin
    logic acc;
    if (rst) begin
      sb.delete();
      m_valid = 1'b0;
      m_prev  = 8'd0;
      m_count = 0;
    end else begin
      chk("inReady", int'(bus.inReady), int'(!m_valid || bus.outReady));
      chk("outValid", int'(bus.outValid), int'(m_valid));
      chk("count", int'(bus.count), m_count);
      if (m_valid && bus.outReady) begin
        if (bus.restart) begin
          if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("sb_out", int'(bus.out), int'(sb.pop_front()));
          m_count = (m_count + 1) % 65536;
        end
      end
      acc = bus.ceDiff && (!m_valid || bus.outReady) && !bus.restart;
      if (bus.restart) begin
        m_valid = 1'b0;
        m_prev  = 8'd0;
        m_count = 0;
      end else if (acc) begin
        if (!loop_mode) sb.push_back(bus.in - m_prev);
        m_prev  = bus.in;
        m_valid = 1'b1;
      end else if (bus.outReady) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc(input logic ce, input logic [7:0] d, input logic ordy, input logic rs);
    @(posedge clk);
    #1;
    bus.ceDiff   = ce;
    bus.in       = d;
    bus.outReady = ordy;
    bus.restart  = rs;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.ceDiff   = 1'b0;
    bus.restart  = 1'b0;
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[4];
    int   samples;
    logic [7:0] acc_sum;
    tbl[0] = '{in: 8'd5,  exp: 8'd5};
    tbl[1] = '{in: 8'd12, exp: 8'd7};
    tbl[2] = '{in: 8'd12, exp: 8'd0};
    tbl[3] = '{in: 8'd3,  exp: 8'd247};

    bus.in = '0; bus.ceDiff = 0; bus.restart = 0; bus.outReady = 1;
    do_reset();
    @(negedge clk);
    chk("rst_out", int'(bus.out), 0);
    chk("rst_valid", int'(bus.outValid), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_inready", int'(bus.inReady), 1);

    // 1: back-to-back stream including zero increment and wrap.
    for (int i = 0; i < 5; i++) begin
      cyc(i < 4, (i < 4) ? tbl[i].in : 8'd0, 1'b1, 1'b0);
      @(negedge clk);
      if (i > 0) begin
        chk("t1_out", int'(bus.out), int'(tbl[i-1].exp));
        chk("t1_valid", int'(bus.outValid), 1);
      end
    end
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t1_count", int'(bus.count), 4);
    chk("t1_valid_end", int'(bus.outValid), 0);

    // 2: backpressure holds the output and blocks the next sample.
    do_reset();
    cyc(1, 10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 30, 0, 0);
      @(negedge clk);
      chk("t2_hold_out", int'(bus.out), 10);
      chk("t2_inready", int'(bus.inReady), 0);
    end
    cyc(1, 30, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t2_out", int'(bus.out), 20);
    chk("t2_count1", int'(bus.count), 1);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t2_count2", int'(bus.count), 2);

    // 3: idle gaps between samples.
    do_reset();
    cyc(1, 200, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t3_out1", int'(bus.out), 200);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t3_idle_valid", int'(bus.outValid), 0);
    cyc(0, 0, 1, 0);
    cyc(1, 100, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t3_out2", int'(bus.out), 156);

    // 4: restart drops the pending result and the concurrent sample.
    do_reset();
    cyc(1, 50, 1, 0);
    cyc(1, 60, 1, 1);
    @(negedge clk);
    chk("t4_pre_out", int'(bus.out), 50);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t4_valid", int'(bus.outValid), 0);
    chk("t4_count", int'(bus.count), 0);
    chk("t4_out_kept", int'(bus.out), 50);
    cyc(1, 70, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t4_out70", int'(bus.out), 70);
    chk("t4_count0", int'(bus.count), 0);

    // 5: reset while a result is pending.
    do_reset();
    cyc(1, 40, 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.ceDiff = 1'b0;
    @(negedge clk);
    chk("t5_pre_valid", int'(bus.outValid), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_out", int'(bus.out), 0);
    chk("t5_valid", int'(bus.outValid), 0);
    chk("t5_count", int'(bus.count), 0);
    chk("t5_inready", int'(bus.inReady), 1);
    cyc(1, 9, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t5_out9", int'(bus.out), 9);

    // 6: closed loop against a behavioural accumulator.
    do_reset();
    @(negedge clk);
    loop_mode = 1'b1;
    acc_sum   = 8'd0;
    samples   = 0;
    for (int i = 0; i < 5000 && samples < 1000; i++) begin
      logic       ce;
      logic [7:0] inc;
      ce  = ($urandom_range(3) != 0);
      inc = 8'($urandom_range(255));
      if (ce) begin
        acc_sum = acc_sum + inc;
        samples++;
      end
      cyc(ce, acc_sum, 1, 0);
      if (ce) sb.push_back(inc);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    @(negedge clk);
    chk("t6_samples", samples, 1000);
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_count", int'(bus.count), 1000);
    loop_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
